// File: rtl/pin_owner_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pin_owner_arbiter
// Purpose  : Round-robin owner of the shared pad bus with a hi-Z turnaround
//            between owners. Define PIN_ARB_TIMEOUT_EN for hold timeout/lockout.
// Revision : 1.0
// ============================================================================
module pin_owner_arbiter #(
    parameter int NREQ       = 2,
    parameter int PIN_W      = 32,
    parameter int TURNAROUND = 1,
    parameter int PARK_ID    = 0,
    parameter int HOLD_MAX   = 65535
) (
    input  logic                  clock_160,
    input  logic                  res,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*PIN_W-1:0] req_out,
    input  logic [NREQ*PIN_W-1:0] req_dir,
    output logic [NREQ-1:0]       gnt,
    output logic [2:0]            gnt_id,
    output logic                  parked,
    output logic [PIN_W-1:0]      pin_out,
    output logic [PIN_W-1:0]      pin_dir,
    output logic                  tmo
);

    if (NREQ < 2 || NREQ > 8 || TURNAROUND < 1 || PARK_ID < 0 || PARK_ID >= NREQ) begin : g_bad_cfg
        $error("pin_owner_arbiter: illegal NREQ/TURNAROUND/PARK_ID");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_OWN  = 2'd2
    } state_t;

    localparam int         CW   = $clog2(TURNAROUND + 1);
    localparam logic [2:0] PARK = 3'(PARK_ID);

    state_t            state_q, state_d;
    logic [2:0]        tgt_q, tgt_d, rr_q, rr_d, gid_q, gid_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              parked_q, parked_d, tmo_q, tmo_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [PIN_W-1:0]  pout_q, pout_d, pdir_q, pdir_d;

    logic [NREQ-1:0]   tgt_oh, elig, elig_oth;
    logic [PIN_W-1:0]  sel_out, sel_dir;
    logic              owner_req, launch;
    logic [2:0]        nxt;
    logic [3:0]        pk;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] m, input logic [2:0] start);
        logic [3:0] r;
        int         best, d;
        r    = '0;
        best = NREQ;
        for (int k = 0; k < NREQ; k++) begin
            d = (k >= int'(start)) ? k - int'(start) : k + NREQ - int'(start);
            if (m[k] && d < best) begin
                best = d;
                r    = {1'b1, 3'(k)};
            end
        end
        return r;
    endfunction

    always_comb begin
        tgt_oh  = '0;
        sel_out = '0;
        sel_dir = '0;
        for (int k = 0; k < NREQ; k++) begin
            tgt_oh[k] = (tgt_q == 3'(k));
            if (tgt_q == 3'(k)) begin
                sel_out = req_out[k*PIN_W +: PIN_W];
                sel_dir = req_dir[k*PIN_W +: PIN_W];
            end
        end
    end

`ifdef PIN_ARB_TIMEOUT_EN
    logic [15:0]     hold_q, hold_d;
    logic [NREQ-1:0] lock_q, lock_d;
    logic            revoke;
    assign elig   = req & ~lock_q;
    assign revoke = ({1'b0, hold_q} + 17'd1) >= 17'(HOLD_MAX);
`else
    logic unused_hold_max;
    assign elig            = req;
    assign unused_hold_max = (HOLD_MAX != 0);
`endif

    assign elig_oth  = elig & ~tgt_oh;
    assign owner_req = |(req & tgt_oh);
    assign nxt       = (int'(tgt_q) == NREQ - 1) ? 3'd0 : tgt_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        rr_d     = rr_q;
        gid_d    = gid_q;
        cnt_d    = cnt_q;
        parked_d = parked_q;
        gnt_d    = gnt_q;
        pout_d   = pout_q;
        pdir_d   = pdir_q;
        tmo_d    = 1'b0;
        launch   = 1'b0;
        pk       = '0;
`ifdef PIN_ARB_TIMEOUT_EN
        hold_d   = hold_q;
        lock_d   = lock_q & req;
`endif
        case (state_q)
            S_IDLE: begin
                launch = 1'b1;
                pk     = rr_pick(elig, rr_q);
            end
            S_TURN: begin
                gnt_d  = '0;
                pout_d = '0;
                pdir_d = '0;
                if (cnt_q == CW'(1)) begin
                    state_d = S_OWN;
                    gnt_d   = tgt_oh;
                    gid_d   = tgt_q;
                    pout_d  = sel_out;
                    pdir_d  = sel_dir;
`ifdef PIN_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OWN: begin
                pout_d = sel_out;
                pdir_d = sel_dir;
                if (parked_q) begin
                    // A parked owner upgrades in place when it is the only requester.
                    if (|elig_oth) begin
                        launch = 1'b1;
                        pk     = rr_pick(elig, rr_q);
                    end else if (owner_req) begin
                        parked_d = 1'b0;
                    end
                end else if (!owner_req) begin
                    rr_d   = nxt;
                    launch = 1'b1;
                    pk     = rr_pick(elig_oth, nxt);
                end
`ifdef PIN_ARB_TIMEOUT_EN
                else if (|elig_oth) begin
                    if (revoke) begin
                        tmo_d  = 1'b1;
                        lock_d = lock_d | tgt_oh;
                        rr_d   = nxt;
                        launch = 1'b1;
                        pk     = rr_pick(elig_oth, nxt);
                    end else if (hold_q != 16'hFFFF) begin
                        hold_d = hold_q + 16'd1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (launch) begin
            state_d  = S_TURN;
            cnt_d    = CW'(TURNAROUND);
            gnt_d    = '0;
            pout_d   = '0;
            pdir_d   = '0;
            tgt_d    = pk[3] ? pk[2:0] : PARK;
            parked_d = ~pk[3];
        end
    end

    always_ff @(posedge clock_160) begin
        if (res) begin
            state_q  <= S_IDLE;
            tgt_q    <= '0;
            rr_q     <= '0;
            gid_q    <= '0;
            cnt_q    <= '0;
            parked_q <= 1'b0;
            tmo_q    <= 1'b0;
            gnt_q    <= '0;
            pout_q   <= '0;
            pdir_q   <= '0;
`ifdef PIN_ARB_TIMEOUT_EN
            hold_q   <= '0;
            lock_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            rr_q     <= rr_d;
            gid_q    <= gid_d;
            cnt_q    <= cnt_d;
            parked_q <= parked_d;
            tmo_q    <= tmo_d;
            gnt_q    <= gnt_d;
            pout_q   <= pout_d;
            pdir_q   <= pdir_d;
`ifdef PIN_ARB_TIMEOUT_EN
            hold_q   <= hold_d;
            lock_q   <= lock_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gid_q;
    assign parked  = parked_q;
    assign pin_out = pout_q;
    assign pin_dir = pdir_q;
    assign tmo     = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_owner_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_owner_arbiter
// Purpose  : Directed scenarios plus randomized run against a reference model.
// Revision : 1.0
// ============================================================================
module tb_pin_owner_arbiter;

    localparam int NREQ       = 2;
    localparam int PIN_W      = 32;
    localparam int TURNAROUND = 1;
    localparam int PARK_ID    = 0;
    localparam int HOLD_MAX   = 16;

    logic                  clk = 1'b0;
    logic                  res;
    logic [NREQ-1:0]       req;
    logic [NREQ*PIN_W-1:0] req_out, req_dir;
    logic [NREQ-1:0]       gnt;
    logic [2:0]            gnt_id;
    logic                  parked, tmo;
    logic [PIN_W-1:0]      pin_out, pin_dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pin_owner_arbiter #(
        .NREQ(NREQ), .PIN_W(PIN_W), .TURNAROUND(TURNAROUND),
        .PARK_ID(PARK_ID), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clock_160(clk), .res(res), .req(req), .req_out(req_out), .req_dir(req_dir),
        .gnt(gnt), .gnt_id(gnt_id), .parked(parked), .pin_out(pin_out),
        .pin_dir(pin_dir), .tmo(tmo)
    );

    // Reference model: phases 0=idle 1=turnaround 2=owning.
    int               m_ph, m_tgt, m_rr, m_cnt, m_hold;
    logic [NREQ-1:0]  m_lock;
    logic [NREQ-1:0]  e_gnt;
    logic [2:0]       e_id;
    logic             e_park, e_tmo;
    logic [PIN_W-1:0] e_pout, e_pdir;

    function automatic logic [NREQ-1:0] bitof(input int k);
        return NREQ'(1) << k;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] m, input int start);
        for (int i = 0; i < NREQ; i++)
            if ((m & bitof((start + i) % NREQ)) != 0) return (start + i) % NREQ;
        return -1;
    endfunction

    always @(posedge clk) begin : ref_model
        logic [NREQ-1:0] el, oth;
        int              w;
        bit              launch;
        if (res) begin
            m_ph = 0; m_tgt = 0; m_rr = 0; m_cnt = 0; m_hold = 0; m_lock = '0;
            e_gnt = '0; e_id = '0; e_park = 1'b0; e_pout = '0; e_pdir = '0; e_tmo = 1'b0;
        end else begin
            launch = 0;
            w      = -1;
            e_tmo  = 1'b0;
            el     = req;
`ifdef PIN_ARB_TIMEOUT_EN
            el     = req & ~m_lock;
            m_lock = m_lock & req;
`endif
            oth = el & ~bitof(m_tgt);
            if (m_ph == 0) begin
                w = pick(el, m_rr);
                launch = 1;
            end else if (m_ph == 1) begin
                e_gnt = '0; e_pout = '0; e_pdir = '0;
                if (m_cnt == 1) begin
                    m_ph   = 2;
                    e_gnt  = bitof(m_tgt);
                    e_id   = 3'(m_tgt);
                    e_pout = PIN_W'(req_out >> (m_tgt * PIN_W));
                    e_pdir = PIN_W'(req_dir >> (m_tgt * PIN_W));
                    m_hold = 0;
                end else begin
                    m_cnt--;
                end
            end else begin
                e_pout = PIN_W'(req_out >> (m_tgt * PIN_W));
                e_pdir = PIN_W'(req_dir >> (m_tgt * PIN_W));
                if (e_park) begin
                    if (oth != 0) begin
                        w = pick(el, m_rr);
                        launch = 1;
                    end else if ((req & bitof(m_tgt)) != 0) begin
                        e_park = 1'b0;
                    end
                end else if ((req & bitof(m_tgt)) == 0) begin
                    m_rr = (m_tgt + 1) % NREQ;
                    w = pick(oth, m_rr);
                    launch = 1;
                end
`ifdef PIN_ARB_TIMEOUT_EN
                else if (oth != 0) begin
                    if (m_hold < 65535) m_hold++;
                    if (m_hold >= HOLD_MAX) begin
                        e_tmo  = 1'b1;
                        m_lock = m_lock | bitof(m_tgt);
                        m_rr   = (m_tgt + 1) % NREQ;
                        w = pick(oth, m_rr);
                        launch = 1;
                    end
                end
`endif
            end
            if (launch) begin
                m_ph = 1; m_cnt = TURNAROUND;
                e_gnt = '0; e_pout = '0; e_pdir = '0;
                if (w >= 0) begin m_tgt = w; e_park = 1'b0; end
                else begin m_tgt = PARK_ID; e_park = 1'b1; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1;
        req = '0;
        req_out = {32'hA5A5_0F0F, 32'h1234_5678};
        req_dir = {32'h0000_00FF, 32'hFFFF_FFFF};
        tick(); tick();
        checks++;
        if ({gnt, gnt_id, parked, tmo} !== '0) begin
            errors++; $display("FAIL reset_ctl got gnt=%b id=%0d park=%b tmo=%b want zeros", gnt, gnt_id, parked, tmo);
        end
        checks++;
        if (pin_out !== '0 || pin_dir !== '0) begin
            errors++; $display("FAIL reset_pins got out=%h dir=%h want 0", pin_out, pin_dir);
        end
        res = 1'b0;
        tick();
        checks++;
        if (gnt !== 2'b00 || pin_dir !== '0) begin
            errors++; $display("FAIL boot_turn got gnt=%b dir=%h want 00/0", gnt, pin_dir);
        end
        tick();
        checks++;
        if (gnt !== 2'b01 || parked !== 1'b1 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL boot_park got gnt=%b park=%b id=%0d want 01/1/0", gnt, parked, gnt_id);
        end
        tick();
        checks++;
        if (pin_dir !== 32'hFFFF_FFFF || pin_out !== 32'h1234_5678) begin
            errors++; $display("FAIL boot_pins got out=%h dir=%h want 12345678/ffffffff", pin_out, pin_dir);
        end
    endtask

    task automatic test_park_to_core();
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (parked !== 1'b0 || gnt !== 2'b01 || pin_dir !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL unpark got park=%b gnt=%b dir=%h want 0/01/ffffffff", parked, gnt, pin_dir);
            end
        end
    endtask

    task automatic test_handover();
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 2'b01 || pin_dir !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL hold_core got gnt=%b dir=%h want 01/ffffffff", gnt, pin_dir);
            end
        end
        req = 2'b10;
        tick();
        checks++;
        if (gnt !== 2'b00 || pin_dir !== '0) begin
            errors++; $display("FAIL handover_gap got gnt=%b dir=%h want 00/0", gnt, pin_dir);
        end
        tick();
        checks++;
        if (gnt !== 2'b10 || gnt_id !== 3'd1 || pin_dir !== 32'h0000_00FF || pin_out !== 32'hA5A5_0F0F) begin
            errors++; $display("FAIL handover_own got gnt=%b id=%0d out=%h dir=%h want 10/1/a5a50f0f/000000ff",
                               gnt, gnt_id, pin_out, pin_dir);
        end
        req_out[PIN_W +: PIN_W] = 32'h1111_2222;
        checks++;
        if (pin_out !== 32'hA5A5_0F0F) begin
            errors++; $display("FAIL latency_pre got %h want a5a50f0f", pin_out);
        end
        tick();
        checks++;
        if (pin_out !== 32'h1111_2222) begin
            errors++; $display("FAIL latency_post got %h want 11112222", pin_out);
        end
    endtask

    task automatic test_fairness();
        int owner = 1;
        int nxt;
        req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            nxt = 1 - owner;
            req = 2'b11 & ~bitof(owner);
            tick();
            checks++;
            if (gnt !== 2'b00 || pin_dir !== '0) begin
                errors++; $display("FAIL fair_gap round %0d got gnt=%b dir=%h want 00/0", r, gnt, pin_dir);
            end
            req = 2'b11;
            tick();
            checks++;
            if (gnt !== bitof(nxt) || pin_dir !== PIN_W'(req_dir >> (nxt * PIN_W))) begin
                errors++; $display("FAIL fair_grant round %0d got gnt=%b dir=%h want %b", r, gnt, pin_dir, bitof(nxt));
            end
            owner = nxt;
            tick(); tick();
        end
    endtask

    task automatic test_reset_mid_own();
        checks++;
        if (gnt !== 2'b10 || pin_dir !== 32'h0000_00FF) begin
            errors++; $display("FAIL midown_pre got gnt=%b dir=%h want 10/000000ff", gnt, pin_dir);
        end
        res = 1'b1;
        tick();
        checks++;
        if (gnt !== '0 || pin_dir !== '0 || pin_out !== '0 || parked !== 1'b0 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL midown_reset got gnt=%b dir=%h out=%h park=%b id=%0d want zeros",
                               gnt, pin_dir, pin_out, parked, gnt_id);
        end
        res = 1'b0;
        req = 2'b00;
        tick(); tick();
        checks++;
        if (gnt !== 2'b01 || parked !== 1'b1) begin
            errors++; $display("FAIL midown_restart got gnt=%b park=%b want 01/1", gnt, parked);
        end
    endtask

`ifdef PIN_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        req = 2'b10;
        tick(); tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL tmo_setup got gnt=%b want 10", gnt);
        end
        req = 2'b11;
        while (tmo !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != HOLD_MAX || gnt !== 2'b00) begin
            errors++; $display("FAIL tmo_pulse got cycles=%0d gnt=%b want %0d/00", n, gnt, HOLD_MAX);
        end
        tick();
        checks++;
        if (gnt !== 2'b01 || tmo !== 1'b0) begin
            errors++; $display("FAIL tmo_regrant got gnt=%b tmo=%b want 01/0", gnt, tmo);
        end
        req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt === 2'b10) begin
                errors++; $display("FAIL tmo_lockout got gnt=%b want not 10", gnt);
            end
        end
        req = 2'b00;
        tick();
        req = 2'b10;
        tick(); tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL tmo_unlock got gnt=%b want 10", gnt);
        end
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        req = 2'b10;
        tick(); tick();
        req = 2'b11;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt !== 2'b10 || tmo !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL no_timeout got %0d bad cycles want 0", bad);
        end
    endtask
`endif

    task automatic test_random();
        int lastown = -1;
        int zrun = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = req ^ bitof(int'($urandom_range(0, NREQ - 1)));
            req_out = {$urandom, $urandom};
            req_dir = {$urandom, $urandom};
            res = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if ({gnt, gnt_id, parked, tmo} !== {e_gnt, e_id, e_park, e_tmo}) begin
                errors++; $display("FAIL rand_ctl cyc %0d got gnt=%b id=%0d park=%b tmo=%b want %b/%0d/%b/%b",
                                   c, gnt, gnt_id, parked, tmo, e_gnt, e_id, e_park, e_tmo);
            end
            checks++;
            if (pin_out !== e_pout || pin_dir !== e_pdir) begin
                errors++; $display("FAIL rand_pins cyc %0d got out=%h dir=%h want %h/%h", c, pin_out, pin_dir, e_pout, e_pdir);
            end
            if (pin_dir != '0) begin
                if (lastown >= 0 && int'(gnt_id) != lastown) begin
                    checks++;
                    if (zrun < TURNAROUND) begin
                        errors++; $display("FAIL contention cyc %0d got gap=%0d want >=%0d", c, zrun, TURNAROUND);
                    end
                end
                lastown = int'(gnt_id);
                zrun = 0;
            end else begin
                zrun++;
            end
        end
        res = 1'b0;
    endtask

    initial begin
        res = 1'b1;
        req = '0;
        req_out = '0;
        req_dir = '0;
        test_reset();
        test_park_to_core();
        test_handover();
        test_fairness();
        test_reset_mid_own();
`ifdef PIN_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
